qbu_rx_merge_arb: RTL and testbench

// - Frame-atomic 2:1 arbiter that merges the express stream and the reassembled preemptable stream

---
 rtl/qbu_rx_merge_arb.sv | 153 +++++++++++++++
 tb/tb_qbu_rx_merge_arb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbu_rx_merge_arb.sv
// qbu_rx_merge_arb
// Frame-atomic 2:1 arbiter merging the express stream (from the qbu_rx
// splitter) and the reassembled preemptable stream (from PMAC reassembly)
// into a single RX AXIS stream towards the switch core.
//
// Express wins at frame boundaries. A starvation guard forces one
// preemptable frame through once MAX_EXP_BURST express frames have been
// granted while the preemptable stream was waiting.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_e_axis_*            express input (data/user/keep/last/valid), o_e_axis_ready
//   i_p_axis_*            preemptable input, same widths, o_p_axis_ready
//   o_axis_*              merged output through a one-beat register slice
//                         o_axis_user = {src, in_user[14:0]}, src 0 = express
//   i_axis_ready          downstream ready
//   o_starve_evt          pulse in the decision cycle of a forced preemptable grant
module qbu_rx_merge_arb #(
  parameter int DWIDTH        = 8,
  parameter int MAX_EXP_BURST = 4,
  parameter int CNT_W         = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DWIDTH-1:0]     i_e_axis_data,
  input  logic [15:0]           i_e_axis_user,
  input  logic [DWIDTH/8-1:0]   i_e_axis_keep,
  input  logic                  i_e_axis_last,
  input  logic                  i_e_axis_valid,
  output logic                  o_e_axis_ready,
  input  logic [DWIDTH-1:0]     i_p_axis_data,
  input  logic [15:0]           i_p_axis_user,
  input  logic [DWIDTH/8-1:0]   i_p_axis_keep,
  input  logic                  i_p_axis_last,
  input  logic                  i_p_axis_valid,
  output logic                  o_p_axis_ready,
  output logic [DWIDTH-1:0]     o_axis_data,
  output logic [15:0]           o_axis_user,
  output logic [DWIDTH/8-1:0]   o_axis_keep,
  output logic                  o_axis_last,
  output logic                  o_axis_valid,
  input  logic                  i_axis_ready,
  output logic                  o_starve_evt
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_EXP_BURST);
  localparam bit               GUARD_EN = (MAX_EXP_BURST != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_E = 2'd1,
    ST_GNT_P = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   burst_cnt_r;
  logic               slice_free_s;
  logic               guard_s;
  logic               pick_e_s;
  logic               e_xfer_s;
  logic               p_xfer_s;
  // The input user MSB is replaced by the source flag on the output.
  logic               unused_user_msb_s;

  assign unused_user_msb_s = i_e_axis_user[15] ^ i_p_axis_user[15];

  // Output user field: source flag replaces the input MSB.
  function automatic logic [15:0] merge_user(input logic src, input logic [14:0] user);
    return {src, user};
  endfunction

  // Burst counter increment that saturates at the guard threshold.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == MAX_CNT) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Grant decision, input readies, transfer strobes and starvation pulse.
  always_comb begin
    slice_free_s   = !o_axis_valid || i_axis_ready;
    // Guard only matters when preemptable traffic is actually waiting.
    guard_s        = GUARD_EN && i_p_axis_valid && (burst_cnt_r == MAX_CNT);
    pick_e_s       = i_e_axis_valid && !guard_s;
    o_e_axis_ready = 1'b0;
    o_p_axis_ready = 1'b0;
    case (state_r)
      ST_GNT_E: o_e_axis_ready = slice_free_s;
      ST_GNT_P: o_p_axis_ready = slice_free_s;
      default: begin
        o_e_axis_ready = 1'b0;
        o_p_axis_ready = 1'b0;
      end
    endcase
    e_xfer_s     = i_e_axis_valid && o_e_axis_ready;
    p_xfer_s     = i_p_axis_valid && o_p_axis_ready;
    o_starve_evt = (state_r == ST_IDLE) && i_e_axis_valid && guard_s;
  end

  // Arbitration FSM, burst counter and output register slice.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      burst_cnt_r  <= {CNT_W{1'b0}};
      o_axis_valid <= 1'b0;
      o_axis_data  <= {DWIDTH{1'b0}};
      o_axis_user  <= 16'h0000;
      o_axis_keep  <= {(DWIDTH/8){1'b0}};
      o_axis_last  <= 1'b0;
    end else begin
      // Slice reloads only when empty or being drained this cycle.
      if (slice_free_s) begin
        o_axis_valid <= e_xfer_s || p_xfer_s;
        if (e_xfer_s) begin
          o_axis_data <= i_e_axis_data;
          o_axis_user <= merge_user(1'b0, i_e_axis_user[14:0]);
          o_axis_keep <= i_e_axis_keep;
          o_axis_last <= i_e_axis_last;
        end else if (p_xfer_s) begin
          o_axis_data <= i_p_axis_data;
          o_axis_user <= merge_user(1'b1, i_p_axis_user[14:0]);
          o_axis_keep <= i_p_axis_keep;
          o_axis_last <= i_p_axis_last;
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (pick_e_s) begin
            state_r     <= ST_GNT_E;
            // Only count express grants that made preemptable traffic wait.
            burst_cnt_r <= i_p_axis_valid ? sat_inc(burst_cnt_r) : {CNT_W{1'b0}};
          end else if (i_p_axis_valid) begin
            state_r     <= ST_GNT_P;
            burst_cnt_r <= {CNT_W{1'b0}};
          end else begin
            burst_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_GNT_E: begin
          if (e_xfer_s && i_e_axis_last) begin
            state_r <= ST_IDLE;
          end
        end
        ST_GNT_P: begin
          if (p_xfer_s && i_p_axis_last) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qbu_rx_merge_arb.sv
// Testbench for qbu_rx_merge_arb: directed stimulus with a scoreboard of
// expected output beats, pushed in the predicted arbitration order.
module tb_qbu_rx_merge_arb;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_e_axis_data, i_p_axis_data;
  logic [15:0] i_e_axis_user, i_p_axis_user;
  logic [0:0]  i_e_axis_keep, i_p_axis_keep;
  logic        i_e_axis_last, i_p_axis_last;
  logic        i_e_axis_valid, i_p_axis_valid;
  logic        o_e_axis_ready, o_p_axis_ready;
  logic [7:0]  o_axis_data;
  logic [15:0] o_axis_user;
  logic [0:0]  o_axis_keep;
  logic        o_axis_last, o_axis_valid;
  logic        i_axis_ready;
  logic        o_starve_evt;

  qbu_rx_merge_arb #(.DWIDTH(8), .MAX_EXP_BURST(4), .CNT_W(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_e_axis_data(i_e_axis_data), .i_e_axis_user(i_e_axis_user),
    .i_e_axis_keep(i_e_axis_keep), .i_e_axis_last(i_e_axis_last),
    .i_e_axis_valid(i_e_axis_valid), .o_e_axis_ready(o_e_axis_ready),
    .i_p_axis_data(i_p_axis_data), .i_p_axis_user(i_p_axis_user),
    .i_p_axis_keep(i_p_axis_keep), .i_p_axis_last(i_p_axis_last),
    .i_p_axis_valid(i_p_axis_valid), .o_p_axis_ready(o_p_axis_ready),
    .o_axis_data(o_axis_data), .o_axis_user(o_axis_user),
    .o_axis_keep(o_axis_keep), .o_axis_last(o_axis_last),
    .o_axis_valid(o_axis_valid), .i_axis_ready(i_axis_ready),
    .o_starve_evt(o_starve_evt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] user;
    logic        keep;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    starve_cnt = 0;
  bit    chk_gap = 1'b0;
  int    exp_gap = 1;
  int    last_out_cyc = -1;
  bit    want_first = 1'b0;
  int    first_out_cyc = 0;
  bit    rnd_ready = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] in_user(input bit src, input int n);
    // MSB set to prove it is discarded; bits 14:12 differ per source.
    return {1'b1, (src ? 3'b101 : 3'b010), 12'(n)};
  endfunction

  task automatic expect_frame(input bit src, input int n, input logic [7:0] base, input int nout);
    logic [15:0] u;
    u = in_user(src, n);
    for (int i = 0; i < nout; i++) begin
      sb.push_back({8'(base + 8'(i)), {src, u[14:0]}, base[0] ^ 1'(i), (i == n - 1)});
    end
  endtask

  task automatic put(input bit src, input logic [7:0] d, input logic [15:0] u,
                     input logic k, input logic l, input logic v);
    if (src) begin
      i_p_axis_data = d; i_p_axis_user = u; i_p_axis_keep = k;
      i_p_axis_last = l; i_p_axis_valid = v;
    end else begin
      i_e_axis_data = d; i_e_axis_user = u; i_e_axis_keep = k;
      i_e_axis_last = l; i_e_axis_valid = v;
    end
  endtask

  // Drive one frame; optional 2-cycle valid gap before beat gap_at and
  // optional reset asserted while beat abort_at is presented.
  task automatic send(input bit src, input int n, input logic [7:0] base,
                      input int gap_at, input int abort_at);
    bit hs;
    int budget;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        put(src, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
      end
      put(src, 8'(base + 8'(i)), in_user(src, n), base[0] ^ 1'(i), (i == n - 1), 1'b1);
      if (i == abort_at) begin
        i_rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(o_axis_valid), 32'd0);
        chk("rst_readies", {30'd0, o_e_axis_ready, o_p_axis_ready}, 32'd0);
        chk("rst_out_data", {15'd0, o_axis_data, o_axis_last, 8'd0}, 32'd0);
        put(src, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        return;
      end
      hs = 1'b0;
      budget = 0;
      while (!hs) begin
        @(negedge i_clk);
        hs = src ? (i_p_axis_valid && o_p_axis_ready) : (i_e_axis_valid && o_e_axis_ready);
        @(posedge i_clk);
        #1;
        budget++;
        if (!hs && budget > 2000) begin
          chk("handshake_timeout", 32'd1, 32'd0);
          put(src, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
          return;
        end
      end
    end
    put(src, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge i_clk);
      n++;
    end
    repeat (2) @(posedge i_clk);
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: scoreboard compare, stall stability, spacing, starve count.
  task automatic monitor();
    beat_t held;
    beat_t cur;
    beat_t e;
    bit    held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        held_v = 1'b0;
      end else begin
        cur = {o_axis_data, o_axis_user, o_axis_keep[0], o_axis_last};
        chk("ready_exclusive", 32'(o_e_axis_ready & o_p_axis_ready), 32'd0);
        if (held_v) begin
          chk("stall_hold_valid", 32'(o_axis_valid), 32'd1);
          chk("stall_hold_beat", 32'(cur), 32'(held));
        end
        if (o_axis_valid && !i_axis_ready) begin
          chk("stall_readies", {30'd0, o_e_axis_ready, o_p_axis_ready}, 32'd0);
          held   = cur;
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
        end
        if (o_starve_evt) starve_cnt++;
        if (o_axis_valid && i_axis_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", 32'(cur), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("out_data", 32'(o_axis_data), 32'(e.data));
            chk("out_user", 32'(o_axis_user), 32'(e.user));
            chk("out_keep", 32'(o_axis_keep), 32'(e.keep));
            chk("out_last", 32'(o_axis_last), 32'(e.last));
          end
          if (want_first) begin
            first_out_cyc = cyc;
            want_first = 1'b0;
          end
          if (chk_gap) begin
            if (last_out_cyc >= 0) chk("beat_spacing", 32'(cyc - last_out_cyc), 32'(exp_gap));
            last_out_cyc = cyc;
          end
        end
      end
    end
  endtask

  initial begin
    int  t0;
    bit  done;
    i_rst = 1'b1;
    i_axis_ready = 1'b0;
    put(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
    put(1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0);
    fork
      monitor();
    join_none
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_outputs", {6'd0, o_axis_data, o_axis_user, o_axis_keep, o_axis_last}, 32'd0);
    chk("reset_ctrl", {28'd0, o_axis_valid, o_e_axis_ready, o_p_axis_ready, o_starve_evt}, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_axis_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;

    // 1: express 64-beat frame alone, latency and full throughput.
    expect_frame(1'b0, 64, 8'h10, 64);
    chk_gap = 1'b1; exp_gap = 1; last_out_cyc = -1;
    want_first = 1'b1;
    t0 = cyc;
    send(1'b0, 64, 8'h10, -1, -1);
    drain();
    chk_gap = 1'b0;
    chk("first_beat_latency", 32'(first_out_cyc - t0), 32'd2);

    // 2: both valid in the same cycle, express first, preemptable after.
    expect_frame(1'b0, 5, 8'h40, 5);
    expect_frame(1'b1, 4, 8'h61, 4);
    fork
      send(1'b0, 5, 8'h40, -1, -1);
      send(1'b1, 4, 8'h61, -1, -1);
    join
    drain();

    // 3: express keeps coming, starvation guard lets one preemptable frame in.
    starve_cnt = 0;
    for (int k = 0; k < 4; k++) expect_frame(1'b0, 2, 8'(8'h80 + 8'(k * 4)), 2);
    expect_frame(1'b1, 3, 8'hA1, 3);
    for (int k = 4; k < 6; k++) expect_frame(1'b0, 2, 8'(8'h80 + 8'(k * 4)), 2);
    fork
      begin
        for (int k = 0; k < 6; k++) send(1'b0, 2, 8'(8'h80 + 8'(k * 4)), -1, -1);
      end
      send(1'b1, 3, 8'hA1, -1, -1);
    join
    drain();
    chk("starve_pulses", 32'(starve_cnt), 32'd1);

    // 4: 100-beat preemptable frame, random downstream ready, valid gap mid-frame.
    expect_frame(1'b1, 100, 8'h03, 100);
    done = 1'b0;
    fork
      begin
        send(1'b1, 100, 8'h03, 50, -1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge i_clk);
          #1;
          i_axis_ready = 1'($urandom_range(0, 1));
        end
        i_axis_ready = 1'b1;
      end
    join
    drain();

    // 5: reset at beat 10 of an express frame, then a clean frame.
    expect_frame(1'b0, 20, 8'h20, 9);
    send(1'b0, 20, 8'h20, -1, 10);
    chk("post_reset_sb", 32'(sb.size()), 32'd0);
    expect_frame(1'b1, 6, 8'hC0, 6);
    send(1'b1, 6, 8'hC0, -1, -1);
    drain();

    // 6: back-to-back single-beat express frames, one beat every 2 cycles.
    for (int k = 0; k < 6; k++) expect_frame(1'b0, 1, 8'(8'hE0 + 8'(k)), 1);
    chk_gap = 1'b1; exp_gap = 2; last_out_cyc = -1;
    for (int k = 0; k < 6; k++) send(1'b0, 1, 8'(8'hE0 + 8'(k)), -1, -1);
    drain();
    chk_gap = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
